axi_rd_arbiter: RTL and testbench

Shares one AXI3 read channel (AR/R) among N read requesters in the fetch/memory path: icache line refill, dcache line refill and the uncached instruction/data port. One transaction is in flight at a time. The block grants a requester, drives the AR handshake and steers R beats back to the owner until `rlast`. AW/W/B are not touched; the write path sits beside this block.

---
 rtl/axi_rd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI3 read-channel arbiter for icache, dcache and uncached requesters.
// Define ARB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module axi_rd_arbiter #(
  parameter int N       = 3,
  parameter int ID_BASE = 0
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] req_addr,
  input  logic [4*N-1:0]  req_len,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    rd_valid,
  output logic [31:0]     rd_data,
  output logic            rd_last,
  output logic            rd_err,
  output logic            busy,
  output logic [3:0]      arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [3:0]      rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic [OW-1:0] own;
  logic [OW-1:0] win;
  logic [31:0]   sel_addr;
  logic [3:0]    sel_len;
  logic          any_req;
  logic          ar_hs;
  logic          beat;
  logic          unused_rid;

  assign any_req    = |req;
  assign ar_hs      = arvalid && arready;
  assign beat       = rready && rvalid;
  // Only one transaction is ever outstanding, so the returned ID carries no routing information.
  assign unused_rid = ^rid;

  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

`ifdef ARB_RR_EN
  logic [OW-1:0] last;
  logic [OW-1:0] lo_win;
  logic [OW-1:0] hi_win;
  logic          hi_found;

  // Search from last+1 wrapping: the lowest requester above last wins, else the lowest overall.
  always_comb begin
    lo_win   = '0;
    hi_win   = '0;
    hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_win = OW'(j);
        if (j > int'(last)) begin
          hi_win   = OW'(j);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last <= OW'(N - 1);
    end else if (state == IDLE && any_req) begin
      last <= win;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        win = OW'(j);
      end
    end
  end
`endif

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int j = 0; j < N; j++) begin
      if (OW'(j) == win) begin
        sel_addr = req_addr[32*j +: 32];
        sel_len  = req_len[4*j +: 4];
      end
    end
  end

  // Handshake and beat steering are combinational so the owner sees them in the same cycle.
  always_comb begin
    ack      = '0;
    rd_valid = '0;
    for (int j = 0; j < N; j++) begin
      ack[j]      = ar_hs && (own == OW'(j));
      rd_valid[j] = beat && (own == OW'(j));
    end
  end

  assign rd_data = rdata;
  assign rd_last = beat && rlast;
  assign rd_err  = beat && (rresp != 2'b00);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      own     <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      busy    <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      arid    <= 4'(ID_BASE);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ADDR;
            own     <= win;
            araddr  <= sel_addr;
            arlen   <= sel_len;
            arid    <= 4'(ID_BASE + int'(win));
            arvalid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            state   <= DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        DATA: begin
          // Error responses do not end the burst; only rlast does.
          if (rvalid && rlast) begin
            state  <= IDLE;
            rready <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          arvalid <= 1'b0;
          rready  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single read, delayed AR, error beat, contention, reset mid-burst.
module tb_axi_rd_arbiter;

  localparam int N = 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N-1:0]  req;
  logic [95:0]   req_addr;
  logic [11:0]   req_len;
  logic [N-1:0]  ack;
  logic [N-1:0]  rd_valid;
  logic [31:0]   rd_data;
  logic          rd_last;
  logic          rd_err;
  logic          busy;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [1:0]    arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  int total  = 0;
  int passed = 0;
  int exp_g[4];

  axi_rd_arbiter #(.N(N), .ID_BASE(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .req_addr(req_addr), .req_len(req_len),
    .ack(ack), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
    .busy(busy), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    aresetn  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    arready  = 1'b0;
    rid      = '0;
    rdata    = '0;
    rresp    = '0;
    rlast    = 1'b0;
    rvalid   = 1'b0;
    tick();
    tick();
    #1;
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_arid", 64'(arid), 64'd0);
    check("const_ar", 64'({arsize, arburst, arlock, arcache, arprot}), 64'({3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}));
    aresetn = 1'b1;

    // Single uncached read
    tick();
    req = 3'b100; req_addr[64 +: 32] = 32'h1FC0_0000; req_len[8 +: 4] = 4'd0; arready = 1'b1;
    #1;
    check("t1_arvalid_idle", 64'(arvalid), 64'd0);
    tick(); #1;
    check("t1_arvalid", 64'(arvalid), 64'd1);
    check("t1_arid", 64'(arid), 64'd2);
    check("t1_arlen", 64'(arlen), 64'd0);
    check("t1_araddr", 64'(araddr), 64'h1FC0_0000);
    check("t1_ack", 64'(ack), 64'b100);
    check("t1_busy", 64'(busy), 64'd1);
    req = '0;
    tick();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b00;
    #1;
    check("t1_rready", 64'(rready), 64'd1);
    check("t1_arvalid_data", 64'(arvalid), 64'd0);
    check("t1_rd_valid", 64'(rd_valid), 64'b100);
    check("t1_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
    check("t1_rd_last", 64'(rd_last), 64'd1);
    check("t1_rd_err", 64'(rd_err), 64'd0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_rready_end", 64'(rready), 64'd0);

    // icache line refill, arready delayed 3 cycles
    arready = 1'b0;
    req = 3'b001; req_addr[0 +: 32] = 32'h0000_1000; req_len[0 +: 4] = 4'd7;
    tick(); #1;
    for (int d = 0; d < 3; d++) begin
      check("t2_arvalid_wait", 64'(arvalid), 64'd1);
      check("t2_araddr_wait", 64'(araddr), 64'h0000_1000);
      check("t2_arlen_wait", 64'(arlen), 64'd7);
      check("t2_ack_wait", 64'(ack), 64'd0);
      tick(); #1;
    end
    arready = 1'b1;
    #1;
    check("t2_ack", 64'(ack), 64'b001);
    req = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      arready = 1'b0; rvalid = 1'b1; rdata = 32'hA000_0000 + 32'(i); rlast = (i == 7);
      #1;
      check("t2_rd_valid", 64'(rd_valid), 64'b001);
      check("t2_rd_data", 64'(rd_data), 64'(32'hA000_0000 + 32'(i)));
      check("t2_rd_last", 64'(rd_last), 64'(i == 7));
      check("t2_busy", 64'(busy), 64'd1);
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t2_busy_end", 64'(busy), 64'd0);

    // Error response on beat 3 of 8
    arready = 1'b1;
    req = 3'b010; req_addr[32 +: 32] = 32'h2000_0040; req_len[4 +: 4] = 4'd7;
    tick(); #1;
    check("t3_ack", 64'(ack), 64'b010);
    check("t3_arid", 64'(arid), 64'd1);
    req = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      rvalid = 1'b1; rdata = 32'(i); rlast = (i == 7); rresp = (i == 3) ? 2'b10 : 2'b00;
      #1;
      check("t3_rd_valid", 64'(rd_valid), 64'b010);
      check("t3_rd_err", 64'(rd_err), 64'(i == 3));
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
    check("t3_busy_end", 64'(busy), 64'd0);
    check("t3_rd_valid_end", 64'(rd_valid), 64'd0);

    // Contention from a fresh reset, all three requesting continuously
    aresetn = 1'b0;
    tick();
`ifdef ARB_RR_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    aresetn = 1'b1;
    req = 3'b111; req_len = '0; arready = 1'b1;
    req_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    for (int g = 0; g < 4; g++) begin
      tick(); #1;
      check("ct_ack", 64'(ack), 64'(1) << exp_g[g]);
      check("ct_arid", 64'(arid), 64'(exp_g[g]));
      tick();
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'(g);
      #1;
      check("ct_rd_valid", 64'(rd_valid), 64'(1) << exp_g[g]);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      check("ct_bubble", 64'(busy), 64'd0);
    end
    req = '0;

    // Reset in the middle of a burst
    tick();
    req = 3'b001; req_addr[0 +: 32] = 32'h0000_2000; req_len[0 +: 4] = 4'd7;
    tick(); #1;
    check("rm_ack", 64'(ack), 64'b001);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rvalid = 1'b1; rlast = 1'b0; rdata = 32'(i);
      #1;
      check("rm_rd_valid", 64'(rd_valid), 64'b001);
    end
    tick();
    aresetn = 1'b0;
    #1;
    check("rm_rready", 64'(rready), 64'd0);
    check("rm_rd_valid_rst", 64'(rd_valid), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    tick();
    rvalid = 1'b0; aresetn = 1'b1;
    req = 3'b010; req_addr[32 +: 32] = 32'h0000_3000; req_len[4 +: 4] = 4'd0;
    #1;
    check("rm_idle", 64'(arvalid), 64'd0);
    tick(); #1;
    check("rm2_arvalid", 64'(arvalid), 64'd1);
    check("rm2_arid", 64'(arid), 64'd1);
    check("rm2_araddr", 64'(araddr), 64'h0000_3000);
    check("rm2_ack", 64'(ack), 64'b010);
    req = '0;
    tick();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_AAAA;
    #1;
    check("rm2_rd_valid", 64'(rd_valid), 64'b010);
    check("rm2_rd_data", 64'(rd_data), 64'h5555_AAAA);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("rm2_busy_end", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
